// File: rtl/bram_bitmap_ctrl.sv
// bram_bitmap_ctrl
//   Bit-granular set/clear/test controller over a 1-bit-wide synchronous BRAM,
//   keeping a live population count of set bits. After reset (or on request)
//   the whole memory is swept to zero before any request is accepted.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   init_start / busy     full-clear request (IDLE only) / clear in progress
//   req_valid/ready/op/addr  request channel (op: 00 TEST, 01 SET, 10 CLEAR, 11 TEST)
//   rsp_valid/ready/data  response channel, data = bit value before the operation
//   pop_count             number of bits currently set (0..2^ABITS)
//   A0, D0, WE0, CE0, Q0  BRAM port 0 (Q0 valid one cycle after a read)
module bram_bitmap_ctrl #(
  parameter int unsigned ABITS = 14
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             init_start,
  output logic             busy,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ABITS-1:0] req_addr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_data,
  output logic [ABITS:0]   pop_count,
  output logic [ABITS-1:0] A0,
  output logic             D0,
  output logic             WE0,
  output logic             CE0,
  input  logic             Q0
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD,
    S_WR,
    S_RSP
  } state_t;

  localparam logic [ABITS:0] POP_MAX = {1'b1, {ABITS{1'b0}}};

  state_t           state, state_nx;
  logic [ABITS-1:0] sweep;
  logic [1:0]       op_q;
  logic [ABITS-1:0] addr_q;
  logic             is_set, is_clr;
  logic             accept, start_init;

  assign is_set     = (op_q == 2'b01);
  assign is_clr     = (op_q == 2'b10);
  assign start_init = (state == S_IDLE) && init_start;
  // init_start wins over a simultaneous request
  assign accept     = (state == S_IDLE) && !init_start && req_valid;

  assign busy      = (state == S_INIT);
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RSP);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_INIT;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT: if (sweep == '1) state_nx = S_IDLE;
      S_IDLE: begin
        if (init_start)     state_nx = S_INIT;
        else if (req_valid) state_nx = S_RD;
      end
      S_RD:   state_nx = S_WR;
      S_WR:   state_nx = S_RSP;
      S_RSP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  // BRAM port decode
  always_comb begin
    A0  = '0;
    D0  = 1'b0;
    WE0 = 1'b0;
    CE0 = 1'b0;
    unique case (state)
      S_INIT: begin
        A0  = sweep;
        WE0 = 1'b1;
        CE0 = 1'b1;
      end
      S_RD: begin
        A0  = addr_q;
        CE0 = 1'b1;
      end
      S_WR: begin
        if (is_set || is_clr) begin
          A0  = addr_q;
          D0  = is_set;
          WE0 = 1'b1;
          CE0 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sweep counter wraps back to 0 on its last INIT cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sweep <= '0;
    end else if (state == S_INIT) begin
      sweep <= sweep + ABITS'(1);
    end else if (start_init) begin
      sweep <= '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q   <= '0;
      addr_q <= '0;
    end else if (accept) begin
      op_q   <= req_op;
      addr_q <= req_addr;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rsp_data <= 1'b0;
    end else if (state == S_WR) begin
      rsp_data <= Q0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pop_count <= '0;
    end else if (start_init || state == S_INIT) begin
      pop_count <= '0;
    end else if (state == S_WR) begin
      if (is_set && !Q0 && pop_count != POP_MAX) begin
        pop_count <= pop_count + (ABITS+1)'(1);
      end else if (is_clr && Q0 && pop_count != '0) begin
        pop_count <= pop_count - (ABITS+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_bram_bitmap_ctrl.sv
module tb_bram_bitmap_ctrl;

  localparam int unsigned ABITS = 14;
  localparam int unsigned DEPTH = 1 << ABITS;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             init_start = 1'b0;
  logic             busy;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [ABITS-1:0] req_addr = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic             rsp_data;
  logic [ABITS:0]   pop_count;
  logic [ABITS-1:0] A0;
  logic             D0, WE0, CE0;
  logic             Q0 = 1'b0;

  bram_bitmap_ctrl #(.ABITS(ABITS)) dut (
    .CLK(CLK), .RST(RST), .init_start(init_start), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .pop_count(pop_count), .A0(A0), .D0(D0), .WE0(WE0), .CE0(CE0), .Q0(Q0)
  );

  always #5 CLK = ~CLK;

  // Attached BRAM: 1-bit wide, synchronous read
  logic bram [DEPTH];
  always @(posedge CLK) begin
    if (CE0) begin
      if (WE0) bram[A0] <= D0;
      else     Q0 <= bram[A0];
    end
  end

  // Reference model: expected content of every bit and the count of set bits
  bit model [DEPTH];
  int model_pop;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int unsigned i = 0; i < DEPTH; i++) model[i] = 1'b0;
    model_pop = 0;
  endtask

  // Called at the negedge where the sweep's first cycle (A0=0) is visible
  task automatic check_sweep(input string tag);
    int bad = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!(busy && CE0 && WE0 && !D0 && A0 == ABITS'(i) && !req_ready && !rsp_valid)) bad++;
      @(negedge CLK);
    end
    check({tag, "_bad_cycles"}, bad, 0);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_pop"}, pop_count, 0);
    check({tag, "_idle_ce"}, CE0, 0);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [ABITS-1:0] addr, input int stall);
    int  t;
    bit  exp_old;
    bit  wr;
    t = 0;
    while (!req_ready && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
    exp_old = model[addr];
    wr = (op == 2'b01) || (op == 2'b10);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    @(negedge CLK);                      // RD
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = ABITS'($urandom);
    check("rd_ce", CE0, 1);
    check("rd_we", WE0, 0);
    check("rd_addr", A0, addr);
    check("rd_ready", req_ready, 0);
    @(negedge CLK);                      // WR
    check("wr_ce", CE0, wr);
    check("wr_we", WE0, wr);
    check("wr_d", D0, op == 2'b01);
    if (wr) check("wr_addr", A0, addr);
    if (op == 2'b01 && !exp_old) model_pop++;
    if (op == 2'b10 &&  exp_old) model_pop--;
    if (op == 2'b01) model[addr] = 1'b1;
    if (op == 2'b10) model[addr] = 1'b0;
    @(negedge CLK);                      // RSP
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, exp_old);
      check("stall_ce", CE0, 0);
      check("stall_ready", req_ready, 0);
      @(negedge CLK);
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, exp_old);
    check("rsp_pop", pop_count, model_pop);
    rsp_ready = 1'b1;
    @(negedge CLK);                      // back to IDLE
    rsp_ready = 1'b0;
    check("idle_valid", rsp_valid, 0);
    check("idle_ready", req_ready, 1);
  endtask

  logic [ABITS-1:0] pool [8];
  logic [ABITS-1:0] a;

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) bram[i] = 1'($urandom);
    pool[0] = 14'h0000; pool[1] = 14'h3FFF; pool[2] = 14'h1234;
    for (int i = 3; i < 8; i++) pool[i] = ABITS'($urandom);

    // Reset state
    repeat (3) @(negedge CLK);
    check("rst_busy", busy, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_pop", pop_count, 0);
    check("rst_a0", A0, 0);
    check("rst_ready", req_ready, 0);
    RST = 1'b0;
    model_clear();
    check_sweep("sweep0");

    // Directed: top address set twice, cleared twice
    do_req(2'b01, 14'h3FFF, 0);
    check("top_pop1", pop_count, 1);
    do_req(2'b01, 14'h3FFF, 0);
    check("top_pop2", pop_count, 1);
    do_req(2'b10, 14'h3FFF, 0);
    check("top_pop3", pop_count, 0);
    do_req(2'b10, 14'h3FFF, 0);
    check("top_pop4", pop_count, 0);
    // SET then TEST, and reserved op as TEST
    do_req(2'b01, 14'h1234, 0);
    check("set1234_pop", pop_count, 1);
    do_req(2'b00, 14'h1234, 0);
    do_req(2'b11, 14'h1234, 10);
    do_req(2'b11, 14'h0000, 3);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      a = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) a = ABITS'($urandom);
      do_req(2'($urandom), a, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : 0);
    end

    // Make sure some bits are set, then init_start collides with a request
    do_req(2'b01, pool[5], 0);
    do_req(2'b01, 14'h1234, 0);
    init_start = 1'b1;
    req_valid  = 1'b1;
    req_op     = 2'b01;
    req_addr   = pool[6];
    @(negedge CLK);
    init_start = 1'b0;
    req_valid  = 1'b0;
    check("init_busy", busy, 1);
    check("init_pop", pop_count, 0);
    check("init_a0", A0, 0);
    model_clear();
    check_sweep("sweep1");
    do_req(2'b00, pool[5], 0);
    do_req(2'b00, pool[6], 0);
    do_req(2'b00, 14'h1234, 0);

    // Reset asserted while a SET is in WR
    do_req(2'b01, 14'h0042, 0);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = 14'h0777;
    @(negedge CLK);                      // RD
    req_valid = 1'b0;
    @(negedge CLK);                      // WR
    RST = 1'b1;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 1);
    check("mid_rst_a0", A0, 0);
    check("mid_rst_pop", pop_count, 0);
    check("mid_rst_data", rsp_data, 0);
    @(negedge CLK);
    RST = 1'b0;
    model_clear();
    check_sweep("sweep2");
    do_req(2'b00, 14'h0777, 0);
    do_req(2'b00, 14'h0042, 0);
    for (int n = 0; n < 60; n++) begin
      do_req(2'($urandom), pool[$urandom_range(0, 7)], $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
